gat_host_bridge: RTL and testbench

- Parametrised host-side bridge between AXI-BRAM-controller ports (32-bit data, byte addresses) and the GAT core's narrow, word-addressed load BRAMs, plus the feature readback port.
- Adds features the plain wrapper lacks:
  - NUM_CH generic load channels.
  - Registered write path.
  - Per-channel write counters.
  - Load/run/done sequencing FSM with a core start pulse.
  - Sticky protocol-error flags.
  - Latency-matched readback.
- Sits between the register bank / BRAM controllers and gat_top.

---
 rtl/gat_host_bridge_if.sv | 26 ++
 rtl/gat_host_bridge.sv | 146 ++++++++++++++
 tb/tb_gat_host_bridge.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gat_host_bridge_if.sv
// Write-path bundle between the host BRAM-controller ports and the core load BRAMs.
// The bridge takes the slave view: host_* in, registered core_* out.
interface gat_host_bridge_if #(
   parameter int TOP_WIDTH = 32,
   parameter int NUM_CH    = 3,
   parameter int CH_DATA_W = 21,
   parameter int CH_ADDR_W = 18
);
   logic [NUM_CH*TOP_WIDTH-1:0]     host_din;
   logic [NUM_CH-1:0]               host_ena;
   logic [NUM_CH-1:0]               host_wea;
   logic [NUM_CH*(CH_ADDR_W+2)-1:0] host_addra;
   logic [NUM_CH*CH_DATA_W-1:0]     core_din;
   logic [NUM_CH-1:0]               core_we;
   logic [NUM_CH*CH_ADDR_W-1:0]     core_addr;

   modport master (
      output host_din, host_ena, host_wea, host_addra,
      input  core_din, core_we, core_addr
   );

   modport slave (
      input  host_din, host_ena, host_wea, host_addra,
      output core_din, core_we, core_addr
   );
endinterface

// File: rtl/gat_host_bridge.sv
// Host-side bridge for the GAT core: registered load-channel writes with counters,
// load/run/done sequencing with a core start pulse, sticky error flags and feature readback.
module gat_host_bridge #(
   parameter int TOP_WIDTH   = 32,
   parameter int NUM_CH      = 3,
   parameter int CH_DATA_W   = 21,
   parameter int CH_ADDR_W   = 18,
   parameter int CNT_W       = 20,
   parameter int FEAT_ADDR_W = 16,
   parameter int FEAT_DATA_W = 32,
   parameter int RD_LATENCY  = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   gat_host_bridge_if.slave         bus,
   input  logic [NUM_CH-1:0]        load_done,
   output logic                     core_start,
   input  logic                     core_done,
   output logic                     gat_ready,
   output logic [NUM_CH*CNT_W-1:0]  wr_count,
   output logic [1:0]               err_flags,
   output logic [1:0]               state_dbg,
   input  logic [FEAT_ADDR_W+1:0]   feat_addrb,
   output logic [FEAT_ADDR_W-1:0]   feat_core_addr,
   input  logic [FEAT_DATA_W-1:0]   feat_core_dout,
   output logic [FEAT_DATA_W-1:0]   feat_dout
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [NUM_CH-1:0] wr_req;
   logic [NUM_CH-1:0] acc;
   logic              load_phase;
   logic              all_done;
   logic              none_done;
   logic              start_nxt;
   logic              clr_cnt;
   logic              rej_wr;
   logic              bad_done;

   logic [CNT_W-1:0]       cnt     [NUM_CH];
   logic [FEAT_DATA_W-1:0] rd_pipe [RD_LATENCY];

   // Byte-lane bits and host data bits above CH_DATA_W are intentionally dropped.
   logic unused_bits;
   assign unused_bits = ^{bus.host_din, bus.host_addra, feat_addrb};

   assign wr_req     = bus.host_ena & bus.host_wea;
   assign load_phase = (state == S_IDLE) || (state == S_LOAD);
   assign acc        = wr_req & {NUM_CH{load_phase}};
   assign all_done   = &load_done;
   assign none_done  = ~|load_done;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; an accepted write always wins over a load_done level in IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (|acc)         state_nxt = S_LOAD;
            else if (all_done) state_nxt = S_RUN;
         end
         S_LOAD: if (all_done && !(|acc)) state_nxt = S_RUN;
         S_RUN:  if (core_done)           state_nxt = S_DONE;
         S_DONE: if (none_done)           state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output / event decode
   always_comb begin
      start_nxt = (state != S_RUN) && (state_nxt == S_RUN);
      clr_cnt   = (state == S_DONE) && (state_nxt == S_IDLE);
      rej_wr    = (|wr_req) && !load_phase;
      bad_done  = core_done && (state != S_RUN);
   end

   assign gat_ready = (state == S_DONE);
   assign state_dbg = state;

   // core_start is registered so it lines up with the first cycle of RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_start <= 1'b0;
         err_flags  <= 2'b00;
      end else begin
         core_start <= start_nxt;
         err_flags  <= err_flags | {bad_done, rej_wr};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.core_we   <= '0;
         bus.core_din  <= '0;
         bus.core_addr <= '0;
         for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      end else begin
         bus.core_we <= acc;
         for (int i = 0; i < NUM_CH; i++) begin
            if (acc[i]) begin
               bus.core_din[i*CH_DATA_W +: CH_DATA_W] <=
                  bus.host_din[i*TOP_WIDTH +: CH_DATA_W];
               bus.core_addr[i*CH_ADDR_W +: CH_ADDR_W] <=
                  bus.host_addra[i*(CH_ADDR_W+2)+2 +: CH_ADDR_W];
            end
            if (clr_cnt)
               cnt[i] <= '0;
            else if (acc[i] && (cnt[i] != {CNT_W{1'b1}}))
               cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
      assign wr_count[g*CNT_W +: CNT_W] = cnt[g];
   end

   // feat_core_dout is sampled every cycle; the bridge provides the RD_LATENCY
   // stages so host address-to-data latency is 1+RD_LATENCY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         feat_core_addr <= '0;
         for (int k = 0; k < RD_LATENCY; k++) rd_pipe[k] <= '0;
      end else begin
         feat_core_addr <= feat_addrb[FEAT_ADDR_W+1:2];
         rd_pipe[0]     <= feat_core_dout;
         for (int k = 1; k < RD_LATENCY; k++) rd_pipe[k] <= rd_pipe[k-1];
      end
   end

   assign feat_dout = rd_pipe[RD_LATENCY-1];

endmodule

// File: tb/tb_gat_host_bridge.sv
// Directed self-checking bench for gat_host_bridge: write path, sequencing FSM,
// error flags, counter saturation and latency-matched feature readback.
module tb_gat_host_bridge;
   localparam int TW  = 32;
   localparam int NC  = 3;
   localparam int DW  = 21;
   localparam int AW  = 18;
   localparam int CW  = 3;   // narrow counter so saturation is reachable in a short run
   localparam int FAW = 16;
   localparam int FDW = 32;
   localparam int RL  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NC-1:0]     load_done;
   logic              core_start;
   logic              core_done;
   logic              gat_ready;
   logic [NC*CW-1:0]  wr_count;
   logic [1:0]        err_flags;
   logic [1:0]        state_dbg;
   logic [FAW+1:0]    feat_addrb;
   logic [FAW-1:0]    feat_core_addr;
   logic [FDW-1:0]    feat_core_dout;
   logic [FDW-1:0]    feat_dout;

   int errors = 0;
   int checks = 0;

   gat_host_bridge_if #(.TOP_WIDTH(TW), .NUM_CH(NC), .CH_DATA_W(DW), .CH_ADDR_W(AW)) bus ();

   gat_host_bridge #(
      .TOP_WIDTH(TW), .NUM_CH(NC), .CH_DATA_W(DW), .CH_ADDR_W(AW), .CNT_W(CW),
      .FEAT_ADDR_W(FAW), .FEAT_DATA_W(FDW), .RD_LATENCY(RL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .load_done(load_done),
      .core_start(core_start), .core_done(core_done), .gat_ready(gat_ready),
      .wr_count(wr_count), .err_flags(err_flags), .state_dbg(state_dbg),
      .feat_addrb(feat_addrb), .feat_core_addr(feat_core_addr),
      .feat_core_dout(feat_core_dout), .feat_dout(feat_dout)
   );

   // Asynchronous-read feature memory: word n holds 0xC0DE0000 | n.
   assign feat_core_dout = 32'hC0DE_0000 | 32'(feat_core_addr);

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.host_din   = '0;
      bus.host_ena   = '0;
      bus.host_wea   = '0;
      bus.host_addra = '0;
      load_done      = '0;
      core_done      = 1'b0;
      feat_addrb     = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   task automatic set_wr(input int ch, input logic [AW+1:0] addr, input logic [TW-1:0] data);
      bus.host_ena[ch] = 1'b1;
      bus.host_wea[ch] = 1'b1;
      bus.host_addra[ch*(AW+2) +: (AW+2)] = addr;
      bus.host_din[ch*TW +: TW] = data;
   endtask

   task automatic stop_wr();
      bus.host_ena = '0;
      bus.host_wea = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      tick();
      checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
      checks++; if (bus.core_we !== 3'b000) begin errors++; $display("FAIL reset_core_we: got %b expected 000", bus.core_we); end
      checks++; if (wr_count !== '0) begin errors++; $display("FAIL reset_wr_count: got %h expected 0", wr_count); end
      checks++; if (err_flags !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", err_flags); end
      checks++; if ({gat_ready, core_start} !== 2'b00) begin errors++; $display("FAIL reset_ready_start: got %b expected 00", {gat_ready, core_start}); end
      checks++; if (feat_dout !== 32'h0) begin errors++; $display("FAIL reset_feat_dout: got %h expected 0", feat_dout); end
      rst_n = 1'b1;
   endtask

   task automatic test_single_write();
      do_reset();
      set_wr(0, 20'h00010, 32'hABCDE123);
      tick();
      stop_wr();
      checks++; if (bus.core_we !== 3'b001) begin errors++; $display("FAIL single_we: got %b expected 001", bus.core_we); end
      checks++; if (bus.core_addr[0 +: AW] !== 18'd4) begin errors++; $display("FAIL single_addr: got %h expected 4", bus.core_addr[0 +: AW]); end
      checks++; if (bus.core_din[0 +: DW] !== 21'h0DE123) begin errors++; $display("FAIL single_din: got %h expected 0de123", bus.core_din[0 +: DW]); end
      checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL single_state: got %0d expected 1", state_dbg); end
      checks++; if (wr_count[0 +: CW] !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", wr_count[0 +: CW]); end
      // Byte-lane bits ignored; ch0 data must hold while its strobe is low.
      set_wr(1, 20'h00013, 32'hFFFFFFFF);
      tick();
      stop_wr();
      checks++; if (bus.core_we !== 3'b010) begin errors++; $display("FAIL lane_we: got %b expected 010", bus.core_we); end
      checks++; if (bus.core_addr[AW +: AW] !== 18'd4) begin errors++; $display("FAIL lane_addr: got %h expected 4", bus.core_addr[AW +: AW]); end
      checks++; if (bus.core_din[DW +: DW] !== 21'h1FFFFF) begin errors++; $display("FAIL lane_din: got %h expected 1fffff", bus.core_din[DW +: DW]); end
      checks++; if (bus.core_din[0 +: DW] !== 21'h0DE123) begin errors++; $display("FAIL hold_din: got %h expected 0de123", bus.core_din[0 +: DW]); end
      tick();
      checks++; if (bus.core_we !== 3'b000) begin errors++; $display("FAIL idle_we: got %b expected 000", bus.core_we); end
   endtask

   task automatic test_back_to_back();
      logic [AW+1:0] a;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < NC; i++) begin
            a = 20'((k + i*64) * 4);
            set_wr(i, a, 32'hFFE0_0000 | (i << 16) | k);
         end
         if (k == 4) load_done = 3'b111;
         tick();
         checks++; if (bus.core_we !== 3'b111) begin errors++; $display("FAIL b2b_we k=%0d: got %b expected 111", k, bus.core_we); end
         for (int i = 0; i < NC; i++) begin
            checks++;
            if (bus.core_addr[i*AW +: AW] !== 18'(k + i*64)) begin
               errors++; $display("FAIL b2b_addr k=%0d ch=%0d: got %h expected %h", k, i, bus.core_addr[i*AW +: AW], 18'(k + i*64));
            end
            checks++;
            if (bus.core_din[i*DW +: DW] !== 21'((i << 16) | k)) begin
               errors++; $display("FAIL b2b_din k=%0d ch=%0d: got %h expected %h", k, i, bus.core_din[i*DW +: DW], 21'((i << 16) | k));
            end
         end
      end
      stop_wr();
      checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL load_while_write: got %0d expected 1", state_dbg); end
      load_done = 3'b011;
      tick();
      checks++; if (state_dbg !== 2'd1 || core_start !== 1'b0) begin errors++; $display("FAIL partial_done: got state %0d start %b expected 1/0", state_dbg, core_start); end
      load_done = 3'b111;
      tick();
      checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL run_state: got %0d expected 2", state_dbg); end
      checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL start_pulse: got %b expected 1", core_start); end
      tick();
      checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL start_single: got %b expected 0", core_start); end
      checks++; if (wr_count !== {3'd5, 3'd5, 3'd5}) begin errors++; $display("FAIL counts_555: got %h expected %h", wr_count, {3'd5, 3'd5, 3'd5}); end
   endtask

   task automatic test_rejected_write();
      set_wr(2, 20'h00040, 32'h12345678);
      tick();
      stop_wr();
      checks++; if (bus.core_we !== 3'b000) begin errors++; $display("FAIL rej_we: got %b expected 000", bus.core_we); end
      checks++; if (err_flags !== 2'b01) begin errors++; $display("FAIL rej_err: got %b expected 01", err_flags); end
      checks++; if (wr_count[2*CW +: CW] !== 3'd5) begin errors++; $display("FAIL rej_count: got %0d expected 5", wr_count[2*CW +: CW]); end
   endtask

   task automatic test_done();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      checks++; if (state_dbg !== 2'd3 || gat_ready !== 1'b1) begin errors++; $display("FAIL done_state: got state %0d ready %b expected 3/1", state_dbg, gat_ready); end
      tick();
      checks++; if (state_dbg !== 2'd3) begin errors++; $display("FAIL done_hold: got %0d expected 3", state_dbg); end
      load_done = 3'b000;
      tick();
      checks++; if (state_dbg !== 2'd0 || gat_ready !== 1'b0) begin errors++; $display("FAIL done_idle: got state %0d ready %b expected 0/0", state_dbg, gat_ready); end
      checks++; if (wr_count !== '0) begin errors++; $display("FAIL done_clr_cnt: got %h expected 0", wr_count); end
      checks++; if (err_flags !== 2'b01) begin errors++; $display("FAIL done_err_kept: got %b expected 01", err_flags); end
   endtask

   task automatic test_zero_load();
      load_done = 3'b111;
      tick();
      checks++; if (state_dbg !== 2'd2 || core_start !== 1'b1) begin errors++; $display("FAIL zero_load: got state %0d start %b expected 2/1", state_dbg, core_start); end
      tick();
      checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL zero_load_pulse: got %b expected 0", core_start); end
   endtask

   task automatic test_reset_mid();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (state_dbg !== 2'd0 || gat_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_state: got state %0d ready %b expected 0/0", state_dbg, gat_ready); end
      checks++; if (wr_count !== '0 || err_flags !== 2'b00) begin errors++; $display("FAIL mid_reset_regs: got cnt %h err %b expected 0/00", wr_count, err_flags); end
      clear_inputs();
      tick();
      rst_n = 1'b1;
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      checks++; if (err_flags !== 2'b10 || state_dbg !== 2'd0) begin errors++; $display("FAIL stray_done: got err %b state %0d expected 10/0", err_flags, state_dbg); end
      set_wr(0, 20'h00008, 32'h00000055);
      tick();
      stop_wr();
      checks++; if (bus.core_we !== 3'b001) begin errors++; $display("FAIL inflight_we: got %b expected 001", bus.core_we); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.core_we !== 3'b000 || bus.core_din !== '0) begin errors++; $display("FAIL inflight_drop: got we %b din %h expected 0", bus.core_we, bus.core_din); end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_saturation();
      do_reset();
      set_wr(1, 20'h00100, 32'h0000_0001);
      repeat (9) tick();
      stop_wr();
      tick();
      checks++; if (wr_count[CW +: CW] !== 3'd7) begin errors++; $display("FAIL saturate: got %0d expected 7", wr_count[CW +: CW]); end
      checks++; if (wr_count[0 +: CW] !== 3'd0) begin errors++; $display("FAIL saturate_other: got %0d expected 0", wr_count[0 +: CW]); end
   endtask

   task automatic test_readback();
      do_reset();
      feat_addrb = '0;
      repeat (3) tick();
      feat_addrb = 18'h00020;
      tick();
      checks++; if (feat_core_addr !== 16'd8) begin errors++; $display("FAIL rb_addr: got %h expected 8", feat_core_addr); end
      checks++; if (feat_dout !== 32'hC0DE0000) begin errors++; $display("FAIL rb_lat1: got %h expected c0de0000", feat_dout); end
      feat_addrb = 18'h00043;
      tick();
      checks++; if (feat_core_addr !== 16'd16) begin errors++; $display("FAIL rb_addr2: got %h expected 10", feat_core_addr); end
      checks++; if (feat_dout !== 32'hC0DE0000) begin errors++; $display("FAIL rb_lat2: got %h expected c0de0000", feat_dout); end
      tick();
      checks++; if (feat_dout !== 32'hC0DE0008) begin errors++; $display("FAIL rb_data8: got %h expected c0de0008", feat_dout); end
      tick();
      checks++; if (feat_dout !== 32'hC0DE0010) begin errors++; $display("FAIL rb_data16: got %h expected c0de0010", feat_dout); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_back_to_back();
      test_rejected_write();
      test_done();
      test_zero_load();
      test_reset_mid();
      test_saturation();
      test_readback();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
